clock_buffer: RTL and testbench
===============================

CLOCK_BUFFER -- requirements
Module: clock_buffer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the cycle counter.
REQ-002 SHALL have parameter TICK_DIV, default 4, period in mclk cycles of the tick strobe; legal range 2..2**CNT_W.
REQ-003 SHALL have port mclk, input, 1 bit, master clock; the block's only clock; port position 1.
REQ-004 SHALL have port bclk, output, 1 bit, buffered clock; port position 2.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset sampled on posedge mclk; port position 3.
REQ-006 SHALL have port cycle_cnt, output, CNT_W bits, count of mclk rising edges since reset.
REQ-007 SHALL have port tick, output, 1 bit, one-cycle strobe every TICK_DIV mclk cycles.
REQ-008 SHALL keep port positions 1 and 2 as mclk and bclk, so a two-port positional instantiation (mclk, bclk) stays legal.

Function
REQ-009 SHALL drive bclk as a pure combinational copy of mclk: no register, no latch, no inversion, zero modelled delay.
REQ-010 SHALL give every bclk rising edge the same simulation timestamp as the matching mclk rising edge, and likewise for falling edges.
REQ-011 SHALL give bclk the same period and duty cycle as mclk for any mclk frequency.
REQ-012 SHALL make bclk independent of rst, cycle_cnt and tick: it follows mclk during reset and when rst is X/Z or unconnected.
REQ-013 SHALL increment cycle_cnt by 1 on every posedge mclk with rst low.
REQ-014 SHALL wrap cycle_cnt from 2**CNT_W-1 to 0, with no sticky overflow flag.
REQ-015 SHALL implement tick with an internal divider counter of 0..TICK_DIV-1, incremented each non-reset cycle and wrapping to 0.
REQ-016 SHALL register tick high for exactly one cycle when the divider counter holds TICK_DIV-1, and low otherwise.
REQ-017 SHALL produce its first tick after reset release in the TICK_DIV-th cycle, then every TICK_DIV cycles.
REQ-018 SHALL make cycle_cnt and tick change only on posedge mclk.

Reset
REQ-019 SHALL clear cycle_cnt, the divider counter and tick to 0 on any posedge mclk with rst high.
REQ-020 SHALL give rst priority over counting and wrap when both occur in the same cycle.
REQ-021 SHALL resume from 0 when rst is asserted mid-count, with no partial tick.
REQ-022 SHALL NOT apply reset to bclk.

Structure
REQ-023 SHALL be one module with no sub-modules.
REQ-024 SHALL hold the CNT_W and TICK_DIV defaults as localparams in a shared package clock_buffer_pkg; no typedefs are needed.
REQ-025 SHALL use one continuous assignment for bclk and one clocked process for the counters and tick.
REQ-026 SHALL flag TICK_DIV < 2 with an elaboration-time check.

Verification
REQ-027 SHALL check phase: mclk starts at 0 and toggles every 10 ns; fork-capture two consecutive posedges of mclk and of bclk; timestamps SHALL match exactly (e.g. 10/30 ns on both).
REQ-028 SHALL check frequency: same stimulus; bclk posedge-to-posedge interval SHALL equal the mclk interval, 20 ns; the test SHALL also pass with rst left unconnected.
REQ-029 SHALL check reset: rst high for 3 cycles, then low; cycle_cnt SHALL read 0 during reset, then 1, 2, 3 on the next three posedges; bclk SHALL toggle throughout.
REQ-030 SHALL check wrap: CNT_W=4, run 17 cycles after reset; cycle_cnt SHALL go 15 -> 0 at edge 16 and read 1 at edge 17.
REQ-031 SHALL check tick: TICK_DIV=4; tick SHALL be high on cycles 4, 8 and 12 after reset release and low on all others.
REQ-032 SHALL check mid-count reset: assert rst when cycle_cnt=6; cycle_cnt SHALL be 0 the next cycle, tick SHALL stay low, and the next tick SHALL occur 4 cycles after release.

Source files
------------

// File: rtl/clock_buffer_pkg.sv
// Shared defaults for the clock buffer and its signal bundle.
`timescale 1ns/1ps
package clock_buffer_pkg;

  // Default width of the free-running mclk cycle counter.
  localparam int CNT_W_DEFAULT    = 16;

  // Default period, in mclk cycles, of the tick strobe.
  localparam int TICK_DIV_DEFAULT = 4;

endpackage

// File: rtl/clock_buffer_if.sv
// Signal bundle around one clock_buffer instance.
//
// Protocol: there is no valid/ready handshake here. rst is sampled on the
// rising edge of mclk. cycle_cnt and tick are registered and change only on
// that edge. bclk is a combinational copy of mclk and never waits on anything.
//
// The buffer itself keeps plain ports so that a two-port positional
// instantiation (mclk, bclk) stays legal. Whoever instantiates it wires the
// ports to these bundle members.
`timescale 1ns/1ps
interface clock_buffer_if
  import clock_buffer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic mclk
);

  logic             bclk;
  logic             rst;
  logic [CNT_W-1:0] cycle_cnt;
  logic             tick;

  // Side that drives reset and observes the buffer.
  modport master (
    input  mclk,
    output rst,
    input  bclk,
    input  cycle_cnt,
    input  tick
  );

  // Side seen by the buffer.
  modport slave (
    input  mclk,
    input  rst,
    output bclk,
    output cycle_cnt,
    output tick
  );

endinterface

// File: rtl/clock_buffer.sv
// Clock buffer: bclk is a zero-delay copy of mclk. The block also keeps a
// wrapping count of mclk rising edges and raises a one-cycle tick every
// TICK_DIV cycles.
`timescale 1ns/1ps
module clock_buffer
  import clock_buffer_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             mclk,
  output logic             bclk,
  input  logic             rst,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             tick
);

  // The divider only needs to hold 0..TICK_DIV-1.
  // The guard keeps the width legal when TICK_DIV is too small.
  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // A divider period below 2 cannot produce a one-cycle strobe.
  // A period above 2**CNT_W is outside the supported range.
  if (TICK_DIV < 2) begin : g_bad_div_low
    $error("clock_buffer: TICK_DIV must be at least 2");
  end
  if (longint'(TICK_DIV) > (longint'(1) << CNT_W)) begin : g_bad_div_high
    $error("clock_buffer: TICK_DIV must not exceed 2**CNT_W");
  end

  logic [DIV_W-1:0] div_cnt;

  // Buffered clock: a plain wire copy of mclk.
  // It has no register and no reset, so its edges land on mclk's timestamps.
  assign bclk = mclk;

  // Cycle counter, tick divider and registered tick.
  // Reset wins over counting and over a wrap that falls in the same cycle.
  always_ff @(posedge mclk) begin
    if (rst) begin
      cycle_cnt <= '0;
      div_cnt   <= '0;
      tick      <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
        tick    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_buffer.sv
// Directed testbench for clock_buffer. It checks edge alignment, frequency,
// reset behaviour, counter wrap, tick placement and reset in mid-count.
`timescale 1ns/1ps
module tb_clock_buffer;
  import clock_buffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic mclk;
  logic rst;

  initial mclk = 1'b0;
  always #10 mclk = ~mclk;

  clock_buffer_if #(.CNT_W(16)) bus16 (.mclk(mclk));
  clock_buffer_if #(.CNT_W(4))  bus4  (.mclk(mclk));

  assign bus16.rst = rst;
  assign bus4.rst  = rst;

  clock_buffer #(.CNT_W(16), .TICK_DIV(4)) dut (
    .mclk      (bus16.mclk),
    .bclk      (bus16.bclk),
    .rst       (bus16.rst),
    .cycle_cnt (bus16.cycle_cnt),
    .tick      (bus16.tick)
  );

  clock_buffer #(.CNT_W(4), .TICK_DIV(4)) dut_w4 (
    .mclk      (bus4.mclk),
    .bclk      (bus4.bclk),
    .rst       (bus4.rst),
    .cycle_cnt (bus4.cycle_cnt),
    .tick      (bus4.tick)
  );

  // ---------------- edge recorders ----------------
  time mclk_rise_q[$];
  time bclk_rise_q[$];
  time bclk_fall_q[$];
  int  bclk_rises;
  int  bclk4_rises;

  initial begin
    bclk_rises  = 0;
    bclk4_rises = 0;
  end

  always @(posedge mclk)       mclk_rise_q.push_back($time);
  always @(posedge bus16.bclk) bclk_rise_q.push_back($time);
  always @(negedge bus16.bclk) bclk_fall_q.push_back($time);
  always @(posedge bus16.bclk) bclk_rises  = bclk_rises + 1;
  always @(posedge bus4.bclk)  bclk4_rises = bclk4_rises + 1;

  int tests_run;
  int tests_failed;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge mclk);
    rst = 1'b1;
    repeat (2) @(negedge mclk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  // Called at time 0: the first mclk rises land at 10 and 30 ns, the falls at 20 and 40 ns.
  task automatic test_phase();
    #45;
    tests_run++;
    if (bclk_rise_q.size() < 2 || bclk_fall_q.size() < 2) begin
      tests_failed++;
      $display("FAIL phase_edges: bclk rises=%0d falls=%0d, need at least 2 each",
               bclk_rise_q.size(), bclk_fall_q.size());
    end else begin
      tests_run++;
      if (bclk_rise_q[0] !== 64'd10) begin
        tests_failed++;
        $display("FAIL phase_rise0: got %0t want 10", bclk_rise_q[0]);
      end
      tests_run++;
      if (bclk_rise_q[1] !== 64'd30) begin
        tests_failed++;
        $display("FAIL phase_rise1: got %0t want 30", bclk_rise_q[1]);
      end
      tests_run++;
      if (bclk_fall_q[0] !== 64'd20 || bclk_fall_q[1] !== 64'd40) begin
        tests_failed++;
        $display("FAIL phase_fall: got %0t/%0t want 20/40", bclk_fall_q[0], bclk_fall_q[1]);
      end
    end
  endtask

  // Reset is driven to X here, so bclk must not depend on it.
  task automatic test_frequency();
    rst = 1'bx;
    @(negedge mclk);
    mclk_rise_q.delete();
    bclk_rise_q.delete();
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    tests_run++;
    if (bclk_rise_q.size() < 3 || mclk_rise_q.size() < 3) begin
      tests_failed++;
      $display("FAIL freq_edges: bclk rises=%0d mclk rises=%0d, need 3",
               bclk_rise_q.size(), mclk_rise_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (bclk_rise_q[i+1] - bclk_rise_q[i] !== 64'd20) begin
          tests_failed++;
          $display("FAIL freq_period%0d: got %0t want 20", i, bclk_rise_q[i+1] - bclk_rise_q[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (bclk_rise_q[i] !== mclk_rise_q[i]) begin
          tests_failed++;
          $display("FAIL freq_align%0d: bclk %0t mclk %0t", i, bclk_rise_q[i], mclk_rise_q[i]);
        end
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int r0;
    int r4;
    @(negedge mclk);
    rst = 1'b1;
    r0 = bclk_rises;
    r4 = bclk4_rises;
    for (int i = 0; i < 3; i++) begin
      @(negedge mclk);
      tests_run++;
      if (bus16.cycle_cnt !== 16'd0 || bus16.tick !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold%0d: cnt=%0d tick=%b want 0/0", i, bus16.cycle_cnt, bus16.tick);
      end
    end
    tests_run++;
    if (bclk_rises - r0 !== 3 || bclk4_rises - r4 !== 3) begin
      tests_failed++;
      $display("FAIL reset_bclk_toggle: rises %0d/%0d want 3/3", bclk_rises - r0, bclk4_rises - r4);
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge mclk);
      tests_run++;
      if (bus16.cycle_cnt !== 16'(k)) begin
        tests_failed++;
        $display("FAIL reset_count%0d: got %0d want %0d", k, bus16.cycle_cnt, k);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_cnt;
    logic       exp_tick;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      @(negedge mclk);
      exp_cnt  = 4'(k);
      exp_tick = (k % 4 == 0);
      tests_run++;
      if (bus4.cycle_cnt !== exp_cnt || bus4.tick !== exp_tick) begin
        tests_failed++;
        $display("FAIL wrap_edge%0d: cnt=%0d tick=%b want %0d/%b",
                 k, bus4.cycle_cnt, bus4.tick, exp_cnt, exp_tick);
      end
    end
    // Reach 15 with the divider at its last value, then reset.
    // The wrap and the tick must both lose to reset.
    repeat (14) @(negedge mclk);
    tests_run++;
    if (bus4.cycle_cnt !== 4'd15) begin
      tests_failed++;
      $display("FAIL wrap_pre_reset: got %0d want 15", bus4.cycle_cnt);
    end
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    tests_run++;
    if (bus4.cycle_cnt !== 4'd0 || bus4.tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_reset_priority: cnt=%0d tick=%b want 0/0", bus4.cycle_cnt, bus4.tick);
    end
  endtask

  task automatic test_tick();
    logic exp_tick;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      @(negedge mclk);
      exp_tick = (k == 4 || k == 8 || k == 12);
      tests_run++;
      if (bus16.tick !== exp_tick) begin
        tests_failed++;
        $display("FAIL tick_cycle%0d: got %b want %b", k, bus16.tick, exp_tick);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp_tick;
    do_reset();
    repeat (6) @(negedge mclk);
    tests_run++;
    if (bus16.cycle_cnt !== 16'd6) begin
      tests_failed++;
      $display("FAIL mid_pre: got %0d want 6", bus16.cycle_cnt);
    end
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    tests_run++;
    if (bus16.cycle_cnt !== 16'd0 || bus16.tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: cnt=%0d tick=%b want 0/0", bus16.cycle_cnt, bus16.tick);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge mclk);
      exp_tick = (k == 4 || k == 8);
      tests_run++;
      if (bus16.cycle_cnt !== 16'(k) || bus16.tick !== exp_tick) begin
        tests_failed++;
        $display("FAIL mid_resume%0d: cnt=%0d tick=%b want %0d/%b",
                 k, bus16.cycle_cnt, bus16.tick, k, exp_tick);
      end
    end
    // Reset while the divider sits at its last value: no tick may leak out.
    do_reset();
    repeat (3) @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    tests_run++;
    if (bus16.cycle_cnt !== 16'd0 || bus16.tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_at3: cnt=%0d tick=%b want 0/0", bus16.cycle_cnt, bus16.tick);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    test_phase();
    test_frequency();
    test_reset();
    test_wrap();
    test_tick();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
